// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO with a one-cycle registered
// read latency and presents the words as a valid/ready stream. A 2-entry
// in-order buffer hides the read latency so the stream can move one word per
// cycle. Every LINE_LEN-th word that is accepted carries o_last.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_LEN   = 640,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LINE_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  pop;
  logic                  tail_is_slot1;
  logic [2:0]            pending;

  assign o_valid = (occ != 2'd0);
  assign pop     = o_valid & i_ready;

  // Words the buffer will have to hold once this cycle's pop and capture
  // settle; a new read is only safe while that leaves room for one more.
  assign pending   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign o_fifo_rd = !i_rst & !i_fifo_empty & (pending <= 3'd1);

  // After this cycle's pop, one word still sits in the head, so the arriving
  // word goes into the second slot; otherwise it becomes the head.
  assign tail_is_slot1 = (occ == 2'd2) || ((occ == 2'd1) && !pop);

  assign o_data = slot0;
  assign o_last = o_valid & (cnt == LAST_CNT);
  assign o_busy = (occ != 2'd0) | inflight;

  // Buffer storage: shift the second slot forward on a pop, then drop the
  // word returned by last cycle's read into the tail.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (pop) begin
        slot0 <= slot1;
      end
      if (inflight) begin
        if (tail_is_slot1) begin
          slot1 <= i_fifo_data;
        end else begin
          slot0 <= i_fifo_data;
        end
      end
    end
  end

  // Occupancy and read-in-flight tracking; a reset discards any pending word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      inflight <= o_fifo_rd;
    end
  end

  // Line position counter, advanced once per accepted word and wrapped
  // after the last word of a line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (pop) begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: drives fifo_stream_reader from a behavioural FIFO
// model and checks the stream against a scoreboard of {last, data} entries
// queued when each word is written into the FIFO.
module tb_fifo_stream_reader;

  localparam int DW      = 8;
  localparam int TB_LINE = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          o_fifo_rd;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_busy;

  logic          fifo_rst;
  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fifo_q[$];
  int            fifo_cnt;

  logic [DW:0]   sb_q[$];
  logic [DW:0]   exp;
  int            sent;
  int            total;
  int            bad;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .LINE_LEN  (TB_LINE),
    .CNT_WIDTH (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_fifo_rd   (o_fifo_rd),
    .i_fifo_data (i_fifo_data),
    .i_fifo_empty(i_fifo_empty),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous FIFO model with a registered read port.
  always @(posedge i_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      fifo_q.delete();
      fifo_cnt    <= 0;
      i_fifo_data <= '0;
    end else begin
      if (o_fifo_rd && fifo_q.size() > 0) begin
        i_fifo_data <= fifo_q.pop_front();
      end
      if (fifo_wr) begin
        fifo_q.push_back(fifo_wdata);
      end
      fifo_cnt <= fifo_q.size();
    end
  end

  assign i_fifo_empty = (fifo_cnt == 0);

  // Queue a word for the FIFO write on the next edge and record what the
  // stream must show for it.
  task automatic drive_word(input logic [DW-1:0] d);
    fifo_wr    = 1'b1;
    fifo_wdata = d;
    sb_q.push_back({((sent % TB_LINE) == (TB_LINE - 1)), d});
    sent++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; fifo_rst = 1'b1; i_ready = 1'b1; fifo_wr = 1'b0; fifo_wdata = '0;
    sent = 0; sb_q.delete();
    repeat (2) @(posedge i_clk);
    #1 fifo_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(DW'(8'hC0 + i));
      @(posedge i_clk); #1;
    end
    fifo_wr = 1'b0;
    @(negedge i_clk);
    total += 5;
    if (o_fifo_rd !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd got=%b want=0", o_fifo_rd); end
    if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", o_valid); end
    if (o_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", o_data); end
    if (o_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b want=0", o_last); end
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
    @(posedge i_clk); #1 i_rst = 1'b0;
    #1;
    total++;
    if (o_fifo_rd !== 1'b1) begin bad++; $display("[TB] FAIL first_read got=%b want=1", o_fifo_rd); end
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        total++;
        if (sb_q.size() == 0) begin bad++; $display("[TB] FAIL reset_drain got=%h want=none", o_data); end
        else begin
          exp = sb_q.pop_front();
          if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL reset_drain got=%h want=%h", {o_last, o_data}, exp); end
        end
      end
      @(posedge i_clk); #1;
    end
    total += 2;
    if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL reset_left got=%0d want=0", sb_q.size()); end
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_single();
    i_ready = 1'b1;
    drive_word(8'hA5);
    @(posedge i_clk); #1 fifo_wr = 1'b0;
    total++;
    if (o_fifo_rd !== 1'b1) begin bad++; $display("[TB] FAIL single_rd got=%b want=1", o_fifo_rd); end
    @(posedge i_clk); #1;
    total += 2;
    if (o_fifo_rd !== 1'b0) begin bad++; $display("[TB] FAIL single_rd_pulse got=%b want=0", o_fifo_rd); end
    if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_early got=%b want=0", o_valid); end
    @(posedge i_clk); #1;
    total++;
    if (o_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", o_valid); end
    else begin
      total++;
      exp = sb_q.pop_front();
      if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL single_data got=%h want=%h", {o_last, o_data}, exp); end
    end
    @(posedge i_clk); #1;
    total += 2;
    if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_one_cycle got=%b want=0", o_valid); end
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_burst();
    int wi = 0, delivered = 0, gaps = 0;
    bit started = 0;
    i_ready = 1'b1;
    for (int c = 0; c < 60 && delivered < 16; c++) begin
      if (wi < 16) begin drive_word(DW'(wi)); wi++; end else fifo_wr = 1'b0;
      @(negedge i_clk);
      if (started && !o_valid) gaps++;
      if (o_valid && i_ready) begin
        started = 1;
        total++;
        if (sb_q.size() == 0) begin bad++; $display("[TB] FAIL burst_data got=%h want=none", o_data); end
        else begin
          exp = sb_q.pop_front();
          if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL burst_data got=%h want=%h", {o_last, o_data}, exp); end
        end
        delivered++;
      end
      @(posedge i_clk); #1;
    end
    fifo_wr = 1'b0;
    total += 2;
    if (delivered != 16) begin bad++; $display("[TB] FAIL burst_count got=%0d want=16", delivered); end
    if (gaps != 0) begin bad++; $display("[TB] FAIL burst_gaps got=%0d want=0", gaps); end
  endtask

  task automatic test_backpressure();
    int wi = 0, delivered = 0, stall_left = 0, peak = 0;
    bit stall_done = 0, held_ok = 0;
    logic [DW-1:0] held;
    for (int c = 0; c < 80 && delivered < 16; c++) begin
      if (wi < 16) begin drive_word(DW'(wi)); wi++; end else fifo_wr = 1'b0;
      if (delivered == 3 && !stall_done) begin stall_left = 5; stall_done = 1; held_ok = 0; end
      i_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      @(negedge i_clk);
      if (int'(dut.occ) > peak) peak = int'(dut.occ);
      if (!(o_valid && i_ready) && ({1'b0, dut.occ} + {2'b00, dut.inflight}) == 3'd2) begin
        total++;
        if (o_fifo_rd !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_read got=%b want=0", o_fifo_rd); end
      end
      if (!i_ready && o_valid) begin
        if (!held_ok) begin held = o_data; held_ok = 1; end
        else begin
          total++;
          if (o_data !== held) begin bad++; $display("[TB] FAIL bp_stable got=%h want=%h", o_data, held); end
        end
      end
      if (o_valid && i_ready) begin
        total++;
        if (sb_q.size() == 0) begin bad++; $display("[TB] FAIL bp_data got=%h want=none", o_data); end
        else begin
          exp = sb_q.pop_front();
          if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL bp_data got=%h want=%h", {o_last, o_data}, exp); end
        end
        delivered++;
      end
      @(posedge i_clk); #1;
    end
    fifo_wr = 1'b0; i_ready = 1'b1;
    total += 3;
    if (delivered != 16) begin bad++; $display("[TB] FAIL bp_count got=%0d want=16", delivered); end
    if (peak != 2) begin bad++; $display("[TB] FAIL bp_peak got=%0d want=2", peak); end
    if (sb_q.size() != 0) begin bad++; $display("[TB] FAIL bp_left got=%0d want=0", sb_q.size()); end
  endtask

  task automatic test_line_tag();
    int wi = 0, delivered = 0, lasts = 0;
    i_rst = 1'b1; fifo_rst = 1'b1; fifo_wr = 1'b0;
    sb_q.delete(); sent = 0;
    @(posedge i_clk); #1 i_rst = 1'b0; fifo_rst = 1'b0;
    for (int c = 0; c < 300 && delivered < 10; c++) begin
      if (wi < 10) begin drive_word(DW'(8'h40 + wi)); wi++; end else fifo_wr = 1'b0;
      i_ready = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        total++;
        if (o_last) lasts++;
        if (sb_q.size() == 0) begin bad++; $display("[TB] FAIL tag_data got=%h want=none", {o_last, o_data}); end
        else begin
          exp = sb_q.pop_front();
          if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL tag_data got=%h want=%h", {o_last, o_data}, exp); end
        end
        delivered++;
      end
      @(posedge i_clk); #1;
    end
    fifo_wr = 1'b0; i_ready = 1'b1;
    total += 2;
    if (delivered != 10) begin bad++; $display("[TB] FAIL tag_count got=%0d want=10", delivered); end
    if (lasts != 2) begin bad++; $display("[TB] FAIL tag_lasts got=%0d want=2", lasts); end
  endtask

  task automatic test_reset_mid();
    int delivered = 0;
    bit reached = 0;
    i_ready = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      if (c < 6) drive_word(DW'(8'h80 + c)); else fifo_wr = 1'b0;
      @(posedge i_clk); #1;
      if (dut.occ == 2'd2) reached = 1;
    end
    fifo_wr = 1'b0;
    total++;
    if (!reached) begin bad++; $display("[TB] FAIL mid_fill got=%0d want=2", dut.occ); end
    i_ready = 1'b1;
    #3 i_rst = 1'b1; fifo_rst = 1'b1;
    #1;
    total += 5;
    if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b want=0", o_valid); end
    if (o_data !== '0) begin bad++; $display("[TB] FAIL mid_data got=%h want=00", o_data); end
    if (o_last !== 1'b0) begin bad++; $display("[TB] FAIL mid_last got=%b want=0", o_last); end
    if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", o_busy); end
    if (o_fifo_rd !== 1'b0) begin bad++; $display("[TB] FAIL mid_rd got=%b want=0", o_fifo_rd); end
    sb_q.delete(); sent = 0;
    @(posedge i_clk); #1 i_rst = 1'b0; fifo_rst = 1'b0;
    for (int c = 0; c < 40 && delivered < 4; c++) begin
      if (c < 4) drive_word(DW'(8'h11 + c)); else fifo_wr = 1'b0;
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        total++;
        if (sb_q.size() == 0) begin bad++; $display("[TB] FAIL mid_after got=%h want=none", {o_last, o_data}); end
        else begin
          exp = sb_q.pop_front();
          if ({o_last, o_data} !== exp) begin bad++; $display("[TB] FAIL mid_after got=%h want=%h", {o_last, o_data}, exp); end
        end
        delivered++;
      end
      @(posedge i_clk); #1;
    end
    fifo_wr = 1'b0;
    total++;
    if (delivered != 4) begin bad++; $display("[TB] FAIL mid_count got=%0d want=4", delivered); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_line_tag();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
